// File: rtl/lcd_bus_if.sv
// Bundle of requester handshakes and LCD pin outputs for the HD44780-style bus arbiter.
// The arbiter uses the slave view; requesters and the pin model use the master view.
interface lcd_bus_if;
    logic [1:0]      req_valid;
    logic [1:0]      req_rs;
    logic [1:0][7:0] req_data;
    logic [1:0]      req_last;
    logic [1:0]      req_ready;
    logic            lcd_e;
    logic            lcd_rs;
    logic [7:0]      lcd_data;
    logic [1:0]      grant;
    logic            init_done;
    logic            busy;

    modport slave (
        input  req_valid, req_rs, req_data, req_last,
        output req_ready, lcd_e, lcd_rs, lcd_data, grant, init_done, busy
    );

    modport master (
        output req_valid, req_rs, req_data, req_last,
        input  req_ready, lcd_e, lcd_rs, lcd_data, grant, init_done, busy
    );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// LCD bus sequencer: power-up wait, fixed init commands, then round-robin arbitration
// between two requesters with lock support and lcd_e/rs/data write timing.
//
// state     | meaning
// PWR_WAIT  | counting LCD power-up delay after reset
// INIT_LOAD | latch next init command onto the pins
// SETUP     | rs/data stable, lcd_e low for one cycle
// E_HIGH    | lcd_e pulse
// SETTLE    | post-pulse wait, long after clear/home commands
// IDLE      | arbitrating requesters
module lcd_bus_arbiter #(
    parameter int unsigned INIT_CYC   = 750000,
    parameter int unsigned E_HIGH_CYC = 25,
    parameter int unsigned SETTLE_CYC = 2500,
    parameter int unsigned LONG_CYC   = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    lcd_bus_if.slave   bus
);

    localparam int unsigned CNT_MAX = (INIT_CYC > LONG_CYC) ? INIT_CYC : LONG_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] INIT_LAST   = CW'(INIT_CYC - 1);
    localparam logic [CW-1:0] E_LAST      = CW'(E_HIGH_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYC - 1);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_LOAD,
        SETUP,
        E_HIGH,
        SETTLE,
        IDLE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic          lcd_e_q;
    logic          lcd_rs_q;
    logic [7:0]    lcd_data_q;
    logic [1:0]    grant_q;
    logic          init_done_q;
    logic          lock_q;
    logic          owner_q;
    logic          rr_q;

    logic [1:0]    ready;
    logic          sel;
    logic          long_wait;
    logic [CW-1:0] settle_last;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // With both valid and no lock, the requester opposite the last winner goes first.
    always_comb begin
        ready = 2'b00;
        if (lock_q)
            sel = owner_q;
        else if (&bus.req_valid)
            sel = ~rr_q;
        else
            sel = bus.req_valid[1];
        if (state_q == IDLE)
            ready[sel] = bus.req_valid[sel];
    end

    assign long_wait   = !lcd_rs_q && (lcd_data_q == 8'h01 || lcd_data_q == 8'h02);
    assign settle_last = long_wait ? LONG_LAST : SETTLE_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
            grant_q     <= 2'b00;
            init_done_q <= 1'b0;
            lock_q      <= 1'b0;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            case (state_q)
                PWR_WAIT: begin
                    if (cnt_q == INIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= INIT_LOAD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                INIT_LOAD: begin
                    lcd_rs_q   <= 1'b0;
                    lcd_data_q <= init_cmd(idx_q);
                    state_q    <= SETUP;
                end
                SETUP: begin
                    lcd_e_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= E_HIGH;
                end
                E_HIGH: begin
                    if (cnt_q == E_LAST) begin
                        lcd_e_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SETTLE: begin
                    if (cnt_q == settle_last) begin
                        cnt_q <= '0;
                        if (!init_done_q && idx_q != 2'd3) begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= INIT_LOAD;
                        end else begin
                            init_done_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                IDLE: begin
                    if (|ready) begin
                        lcd_rs_q   <= bus.req_rs[sel];
                        lcd_data_q <= bus.req_data[sel];
                        grant_q    <= sel ? 2'b10 : 2'b01;
                        rr_q       <= sel;
                        owner_q    <= sel;
                        lock_q     <= ~bus.req_last[sel];
                        state_q    <= SETUP;
                    end
                end
                default: state_q <= PWR_WAIT;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.lcd_e     = lcd_e_q;
    assign bus.lcd_rs    = lcd_rs_q;
    assign bus.lcd_data  = lcd_data_q;
    assign bus.grant     = grant_q;
    assign bus.init_done = init_done_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: a write-schedule model predicts every output each cycle,
// directed scenarios pin the model with literal timings, then random traffic runs.
module tb_lcd_bus_arbiter;

    localparam int INIT_CYC   = 10;
    localparam int E_HIGH_CYC = 2;
    localparam int SETTLE_CYC = 3;
    localparam int LONG_CYC   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lcd_bus_if bus();

    lcd_bus_arbiter #(
        .INIT_CYC  (INIT_CYC),
        .E_HIGH_CYC(E_HIGH_CYC),
        .SETTLE_CYC(SETTLE_CYC),
        .LONG_CYC  (LONG_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         setup;
    } wr_t;

    // Model: list of scheduled writes, each fully described by its SETUP cycle.
    wr_t        wq[$];
    wr_t        cur;
    bit         cur_v;
    int         cyc;
    int         idle_cyc;
    int         init_done_cyc;
    int         rr;
    int         owner;
    int         acc_k;
    bit         lock;
    logic [1:0] m_grant;
    logic       m_rs;
    logic [7:0] m_data;

    int         acc_log_k[$];
    logic [7:0] acc_log_d[$];
    int         rise_c[$];
    logic [7:0] rise_d[$];
    logic       rise_rs[$];
    int         width_q[$];
    int         cur_w;
    logic       prev_e;
    int         init_first;

    logic [7:0] init_cmds[4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    int         lit_rise[4]  = '{12, 19, 26, 33};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_timeout(input string what);
        n_chk++;
        $display("FAIL timeout %s: event not seen within bound (cycle %0d)", what, cyc);
    endtask

    function automatic int wait_of(input logic rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02)) ? LONG_CYC : SETTLE_CYC;
    endfunction

    function automatic logic [1:0] exp_ready();
        logic [1:0] r;
        logic [1:0] v;
        r = 2'b00;
        v = bus.req_valid;
        if (cyc >= idle_cyc) begin
            if (lock)           r[owner] = v[owner];
            else if (v == 2'b11) r[1 - rr] = 1'b1;
            else                r = v;
        end
        return r;
    endfunction

    task automatic model_reset();
        int  l;
        wr_t w;
        cyc = 0; wq.delete(); cur_v = 0; m_rs = 1'b0; m_data = 8'h00;
        lock = 0; owner = 0; rr = 0; m_grant = 2'b00; acc_k = -1;
        rise_c.delete(); rise_d.delete(); rise_rs.delete(); width_q.delete();
        cur_w = 0; prev_e = 1'b0; init_first = -1;
        l = INIT_CYC;
        for (int i = 0; i < 4; i++) begin
            w.rs    = 1'b0;
            w.data  = init_cmds[i];
            w.setup = l + 1;
            wq.push_back(w);
            l = w.setup + 1 + E_HIGH_CYC + wait_of(1'b0, init_cmds[i]);
        end
        idle_cyc      = l;
        init_done_cyc = l;
    endtask

    task automatic compare();
        logic e_exp;
        while (wq.size() > 0 && wq[0].setup <= cyc) begin
            cur    = wq.pop_front();
            cur_v  = 1;
            m_rs   = cur.rs;
            m_data = cur.data;
        end
        e_exp = cur_v && (cyc >= cur.setup + 1) && (cyc <= cur.setup + E_HIGH_CYC);
        chk("lcd_e",     bus.lcd_e,     e_exp);
        chk("lcd_rs",    bus.lcd_rs,    m_rs);
        chk("lcd_data",  bus.lcd_data,  m_data);
        chk("grant",     bus.grant,     m_grant);
        chk("init_done", bus.init_done, cyc >= init_done_cyc);
        chk("busy",      bus.busy,      cyc < idle_cyc);
        chk("req_ready", bus.req_ready, exp_ready());
        if (bus.lcd_e && !prev_e) begin
            rise_c.push_back(cyc);
            rise_d.push_back(bus.lcd_data);
            rise_rs.push_back(bus.lcd_rs);
        end
        if (bus.lcd_e) cur_w++;
        else if (prev_e) begin
            width_q.push_back(cur_w);
            cur_w = 0;
        end
        prev_e = bus.lcd_e;
        if (bus.init_done && init_first < 0) init_first = cyc;
    endtask

    task automatic model_edge();
        logic [1:0] r;
        wr_t        w;
        r     = exp_ready();
        acc_k = -1;
        for (int k = 0; k < 2; k++)
            if (r[k] && bus.req_valid[k]) acc_k = k;
        if (acc_k >= 0) begin
            w.rs    = bus.req_rs[acc_k];
            w.data  = bus.req_data[acc_k];
            w.setup = cyc + 1;
            wq.push_back(w);
            idle_cyc = cyc + 2 + E_HIGH_CYC + wait_of(w.rs, w.data);
            m_grant  = (acc_k == 1) ? 2'b10 : 2'b01;
            rr       = acc_k;
            owner    = acc_k;
            lock     = !bus.req_last[acc_k];
            acc_log_k.push_back(acc_k);
            acc_log_d.push_back(w.data);
        end
        cyc++;
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input int k, input logic v, input logic rs, input logic [7:0] d, input logic last);
        bus.req_valid[k] = v;
        bus.req_rs[k]    = rs;
        bus.req_data[k]  = d;
        bus.req_last[k]  = last;
    endtask

    task automatic wait_acc(input int k_want, output int a_cyc);
        bit got;
        got   = 0;
        a_cyc = -1;
        for (int n = 0; n < 300 && !got; n++) begin
            tick();
            if (acc_k >= 0) begin
                got   = 1;
                a_cyc = cyc - 1;
                if (k_want >= 0) chk("accept_owner", acc_k, k_want);
            end
        end
        if (!got) fail_timeout("accept");
    endtask

    task automatic wait_idle(output int idle_c);
        idle_c = -1;
        for (int n = 0; n < 300; n++) begin
            if (!bus.busy) begin
                idle_c = cyc;
                break;
            end
            tick();
        end
        if (idle_c < 0) fail_timeout("idle");
    endtask

    task automatic check_init();
        while (cyc < 50) tick();
        chk("init_pulse_count", rise_c.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rise_c.size()) begin
                chk("init_rise_cycle", rise_c[i], lit_rise[i]);
                chk("init_data",       rise_d[i], init_cmds[i]);
                chk("init_rs",         rise_rs[i], 1'b0);
            end
            if (i < width_q.size()) chk("init_e_width", width_q[i], 2);
        end
        chk("init_done_cycle", init_first, 43);
        if (rise_c.size() == 4) chk("init_long_gap", init_first - rise_c[3] - E_HIGH_CYC, 8);
    endtask

    task automatic single(input int k, input logic rs, input logic [7:0] d, input int exp_idle,
                          input string nm);
        int a, ic, nr;
        nr = rise_c.size();
        drive(k, 1'b1, rs, d, 1'b1);
        wait_acc(k, a);
        drive(k, 1'b0, rs, d, 1'b1);
        wait_idle(ic);
        chk({nm, "_idle_offset"}, ic - a, exp_idle);
        chk({nm, "_pulses"}, rise_c.size(), nr + 1);
        if (rise_c.size() == nr + 1) begin
            chk({nm, "_rise_offset"}, rise_c[nr] - a, 2);
            chk({nm, "_rise_data"},   rise_d[nr], d);
            chk({nm, "_rise_rs"},     rise_rs[nr], rs);
            chk({nm, "_e_width"},     width_q[width_q.size() - 1], 2);
        end
    endtask

    task automatic new_beat(input int k);
        logic       rs;
        logic [7:0] d;
        rs = 1'($urandom_range(1));
        d  = 8'($urandom);
        if (!rs && $urandom_range(3) == 0) d = 8'($urandom_range(2, 1));
        drive(k, 1'b1, rs, d, 1'($urandom_range(9) < 7));
    endtask

    initial begin
        int a, ic, li;
        int g[4];
        bus.req_valid = 2'b00;
        bus.req_rs    = 2'b00;
        bus.req_data  = '0;
        bus.req_last  = 2'b00;

        // Init sequence after power-on reset.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        compare();
        check_init();

        // Single data write.
        single(0, 1'b1, 8'h46, 7, "single");

        // Round-robin with both valid.
        drive(0, 1'b1, 1'b1, 8'hA0, 1'b1);
        drive(1, 1'b1, 1'b1, 8'hB0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_acc(-1, a);
            g[i] = acc_k;
            if (acc_k >= 0) drive(acc_k, 1'b1, 1'b1, 8'(8'hA1 + i), 1'b1);
        end
        drive(0, 1'b0, 1'b1, 8'h00, 1'b1);
        drive(1, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("rr_first", g[0], 1);
        for (int i = 1; i < 4; i++) chk("rr_alternate", g[i], 1 - g[i-1]);
        wait_idle(ic);

        // Long vs short post-pulse waits.
        single(1, 1'b0, 8'h01, 12, "clear_cmd");
        single(1, 1'b1, 8'h01, 7,  "data_01");
        single(1, 1'b0, 8'h02, 12, "home_cmd");

        // Lock: requester 0 keeps the bus across three beats, even while idle.
        li = acc_log_k.size();
        drive(1, 1'b1, 1'b1, 8'h55, 1'b1);
        drive(0, 1'b1, 1'b0, 8'hC0, 1'b0);
        wait_acc(0, a);
        drive(0, 1'b1, 1'b1, 8'h3A, 1'b0);
        wait_acc(0, a);
        drive(0, 1'b0, 1'b1, 8'h3A, 1'b0);
        wait_idle(ic);
        repeat (6) tick();
        drive(0, 1'b1, 1'b1, 8'h29, 1'b1);
        wait_acc(0, a);
        drive(0, 1'b0, 1'b1, 8'h29, 1'b1);
        wait_acc(1, a);
        drive(1, 1'b0, 1'b1, 8'h55, 1'b1);
        wait_idle(ic);
        chk("lock_beats", acc_log_d.size() - li, 4);
        if (acc_log_d.size() - li == 4) begin
            chk("lock_d0", acc_log_d[li],     8'hC0);
            chk("lock_d1", acc_log_d[li + 1], 8'h3A);
            chk("lock_d2", acc_log_d[li + 2], 8'h29);
            chk("lock_d3", acc_log_d[li + 3], 8'h55);
        end

        // Reset during the enable pulse.
        drive(0, 1'b1, 1'b1, 8'h41, 1'b1);
        wait_acc(0, a);
        drive(0, 1'b0, 1'b1, 8'h41, 1'b1);
        drive(1, 1'b1, 1'b1, 8'h77, 1'b1);
        ic = 0;
        for (int n = 0; n < 20 && !bus.lcd_e; n++) tick();
        if (!bus.lcd_e) fail_timeout("lcd_e_rise");
        #2 rst_n = 1'b0;
        #1;
        chk("rst_lcd_e",     bus.lcd_e,     1'b0);
        chk("rst_busy",      bus.busy,      1'b1);
        chk("rst_init_done", bus.init_done, 1'b0);
        chk("rst_grant",     bus.grant,     2'b00);
        chk("rst_req_ready", bus.req_ready, 2'b00);
        drive(1, 1'b0, 1'b1, 8'h77, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        compare();
        check_init();

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (bus.req_valid[k]) begin
                    if (acc_k == k) begin
                        if ($urandom_range(9) < 6) new_beat(k);
                        else bus.req_valid[k] = 1'b0;
                    end else if ($urandom_range(99) < 3) begin
                        bus.req_valid[k] = 1'b0;
                    end
                end else if ($urandom_range(9) < 3) begin
                    new_beat(k);
                end
            end
        end
        bus.req_valid = 2'b00;
        wait_idle(ic);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
